// File: rtl/ndn_fib_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ndn_fib_pkg                                                  |
// | Description : Shared types and sizing for the FIB name-injection front     |
// |               end: component width, words per name, the injector FSM       |
// |               state encoding and the word typedef.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ndn_fib_pkg;

  localparam int WORD_SIZE       = 32;
  localparam int MAX_NAME_LENGTH = 8;

  typedef logic [WORD_SIZE-1:0] word_t;

  // IDLE   : waiting for a requester, one bubble between names
  // STREAM : forwarding words of the granted requester
  // PAD    : name ended early, emitting zero words up to the last index
  // DRAIN  : name too long, swallowing words until the requester's last
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_PAD    = 2'd2,
    ST_DRAIN  = 2'd3
  } inj_state_t;

endpackage
`default_nettype wire

// File: rtl/name_inject_arbiter_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Combinational circular priority pick. Returns the first      |
// |               asserted request at or after rr_ptr, wrapping around.        |
// | Ports       : req     - request vector, one bit per port                   |
// |               rr_ptr  - highest-priority port index                        |
// |               gnt_idx - index of the selected port (0 when none)           |
// |               any     - at least one request present                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_arbiter
  import ndn_fib_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    rr_ptr,
  output logic [PORT_W-1:0]    gnt_idx,
  output logic                 any
);

  int                w_pos;
  logic [PORT_W-1:0] w_sel;

  // Walk offsets from farthest to nearest so the last hit, which is the
  // one closest to rr_ptr, is the one that sticks.
  always_comb begin
    gnt_idx = '0;
    any     = |req;
    w_pos   = 0;
    w_sel   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      w_pos = int'(rr_ptr) + i;
      if (w_pos >= NUM_PORTS) begin
        w_pos = w_pos - NUM_PORTS;
      end
      w_sel = PORT_W'(w_pos);
      if (req[w_sel]) begin
        gnt_idx = w_sel;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/name_inject_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : name_inject_arbiter                                          |
// | Description : Round-robin scheduler feeding the single name_component      |
// |               input of the FIB lookup pipeline. Each granted name is       |
// |               emitted as exactly MAX_NAME_LENGTH words: short names are    |
// |               zero-padded, long names are truncated and their tail is      |
// |               drained from the requester.                                  |
// | Ports       : clk_in, rst_n_in      - clock, async active-low reset        |
// |               req_valid/word/last_in - per-port word streams              |
// |               req_ready_out         - per-port accept (one-hot or zero)    |
// |               pipe_stall_in         - downstream hold                      |
// |               name_component_out, comp_* - registered emitted word + tags  |
// |               overflow_out          - pulse with truncated name's last word|
// |               busy_out              - FSM not idle                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module name_inject_arbiter
  import ndn_fib_pkg::*;
#(
  parameter  int WORD_SIZE       = ndn_fib_pkg::WORD_SIZE,
  parameter  int MAX_NAME_LENGTH = ndn_fib_pkg::MAX_NAME_LENGTH,
  parameter  int NUM_PORTS       = 4,
  localparam int PORT_W          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int IDX_W           = (MAX_NAME_LENGTH > 1) ? $clog2(MAX_NAME_LENGTH) : 1
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic [NUM_PORTS-1:0]           req_valid_in,
  input  logic [NUM_PORTS*WORD_SIZE-1:0] req_word_in,
  input  logic [NUM_PORTS-1:0]           req_last_in,
  output logic [NUM_PORTS-1:0]           req_ready_out,
  input  logic                           pipe_stall_in,
  output logic [WORD_SIZE-1:0]           name_component_out,
  output logic                           comp_valid_out,
  output logic                           comp_first_out,
  output logic                           comp_last_out,
  output logic [IDX_W-1:0]               comp_idx_out,
  output logic [PORT_W-1:0]              comp_port_out,
  output logic                           overflow_out,
  output logic                           busy_out
);

  localparam logic [PORT_W-1:0] c_LAST_PORT = PORT_W'(NUM_PORTS - 1);
  localparam logic [IDX_W-1:0]  c_LAST_IDX  = IDX_W'(MAX_NAME_LENGTH - 1);

  // State and registered outputs
  inj_state_t           r_state;
  logic [PORT_W-1:0]    r_grant;
  logic [PORT_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]     r_word_idx;
  logic                 r_comp_valid;
  logic [WORD_SIZE-1:0] r_comp_word;
  logic                 r_comp_first;
  logic                 r_comp_last;
  logic [IDX_W-1:0]     r_comp_idx;
  logic [PORT_W-1:0]    r_comp_port;
  logic                 r_overflow;

  // Next-state and per-cycle decisions
  inj_state_t           w_state_nxt;
  logic [PORT_W-1:0]    w_grant_nxt;
  logic [PORT_W-1:0]    w_rr_ptr_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 w_emit;
  logic [WORD_SIZE-1:0] w_emit_word;
  logic                 w_overflow;
  logic [NUM_PORTS-1:0] w_ready;

  logic [WORD_SIZE-1:0] w_port_word [NUM_PORTS];
  logic [PORT_W-1:0]    w_arb_idx;
  logic                 w_arb_any;
  logic                 w_sel_valid;
  logic                 w_sel_last;
  logic [WORD_SIZE-1:0] w_sel_word;
  logic                 w_idx_at_max;
  logic [PORT_W-1:0]    w_ptr_after;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign w_port_word[gi] = req_word_in[gi*WORD_SIZE +: WORD_SIZE];
  end

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_rr_arbiter (
    .req     (req_valid_in),
    .rr_ptr  (r_rr_ptr),
    .gnt_idx (w_arb_idx),
    .any     (w_arb_any)
  );

  assign w_sel_valid  = req_valid_in[r_grant];
  assign w_sel_last   = req_last_in[r_grant];
  assign w_sel_word   = w_port_word[r_grant];
  assign w_idx_at_max = (r_word_idx == c_LAST_IDX);
  // Pointer moves past the port that just finished its name
  assign w_ptr_after  = (r_grant == c_LAST_PORT) ? '0 : r_grant + 1'b1;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    w_idx_nxt    = r_word_idx;
    w_emit       = 1'b0;
    w_emit_word  = '0;
    w_overflow   = 1'b0;
    w_ready      = '0;

    case (r_state)
      ST_IDLE: begin
        // Grant only; the first word is taken next cycle, leaving a bubble
        if (w_arb_any) begin
          w_grant_nxt = w_arb_idx;
          w_idx_nxt   = '0;
          w_state_nxt = ST_STREAM;
        end
      end

      ST_STREAM: begin
        w_ready[r_grant] = !pipe_stall_in;
        if (w_sel_valid && !pipe_stall_in) begin
          w_emit      = 1'b1;
          w_emit_word = w_sel_word;
          if (w_sel_last) begin
            if (w_idx_at_max) begin
              w_state_nxt  = ST_IDLE;
              w_rr_ptr_nxt = w_ptr_after;
            end else begin
              w_idx_nxt   = r_word_idx + 1'b1;
              w_state_nxt = ST_PAD;
            end
          end else if (w_idx_at_max) begin
            // Full-length name already emitted; the rest is discarded
            w_overflow  = 1'b1;
            w_state_nxt = ST_DRAIN;
          end else begin
            w_idx_nxt = r_word_idx + 1'b1;
          end
        end
      end

      ST_PAD: begin
        if (!pipe_stall_in) begin
          w_emit = 1'b1;
          if (w_idx_at_max) begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = w_ptr_after;
          end else begin
            w_idx_nxt = r_word_idx + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        // Nothing reaches the pipeline here, so stall is irrelevant
        w_ready[r_grant] = 1'b1;
        if (w_sel_valid && w_sel_last) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = w_ptr_after;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_word_idx   <= '0;
      r_comp_valid <= 1'b0;
      r_comp_word  <= '0;
      r_comp_first <= 1'b0;
      r_comp_last  <= 1'b0;
      r_comp_idx   <= '0;
      r_comp_port  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_word_idx   <= w_idx_nxt;
      r_comp_valid <= w_emit;
      r_comp_word  <= w_emit_word;
      r_comp_first <= w_emit && (r_word_idx == '0);
      r_comp_last  <= w_emit && w_idx_at_max;
      r_comp_idx   <= w_emit ? r_word_idx : '0;
      r_comp_port  <= w_emit ? r_grant : '0;
      r_overflow   <= w_overflow;
    end
  end

  assign req_ready_out      = w_ready;
  assign name_component_out = r_comp_word;
  assign comp_valid_out     = r_comp_valid;
  assign comp_first_out     = r_comp_first;
  assign comp_last_out      = r_comp_last;
  assign comp_idx_out       = r_comp_idx;
  assign comp_port_out      = r_comp_port;
  assign overflow_out       = r_overflow;
  assign busy_out           = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_name_inject_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_name_inject_arbiter                                       |
// | Description : Directed self-checking bench for name_inject_arbiter.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_name_inject_arbiter;
  import ndn_fib_pkg::*;

  localparam int c_W = 32;
  localparam int c_N = 4;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic [c_N-1:0]   req_valid_in;
  logic [c_N*c_W-1:0] req_word_in;
  logic [c_N-1:0]   req_last_in;
  logic [c_N-1:0]   req_ready_out;
  logic             pipe_stall_in;
  logic [c_W-1:0]   name_component_out;
  logic             comp_valid_out;
  logic             comp_first_out;
  logic             comp_last_out;
  logic [2:0]       comp_idx_out;
  logic [1:0]       comp_port_out;
  logic             overflow_out;
  logic             busy_out;

  int n_cmp = 0;
  int n_err = 0;

  name_inject_arbiter #(
    .WORD_SIZE       (c_W),
    .MAX_NAME_LENGTH (8),
    .NUM_PORTS       (c_N)
  ) dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .req_valid_in       (req_valid_in),
    .req_word_in        (req_word_in),
    .req_last_in        (req_last_in),
    .req_ready_out      (req_ready_out),
    .pipe_stall_in      (pipe_stall_in),
    .name_component_out (name_component_out),
    .comp_valid_out     (comp_valid_out),
    .comp_first_out     (comp_first_out),
    .comp_last_out      (comp_last_out),
    .comp_idx_out       (comp_idx_out),
    .comp_port_out      (comp_port_out),
    .overflow_out       (overflow_out),
    .busy_out           (busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_out();
    return {23'd0, comp_valid_out, name_component_out, comp_first_out,
            comp_last_out, comp_idx_out, comp_port_out, overflow_out};
  endfunction

  function automatic logic [63:0] exp_vec(input logic v, input logic [31:0] w,
                                          input logic [2:0] idx, input logic [1:0] port,
                                          input logic ovf);
    if (!v) return 64'd0;
    return {23'd0, 1'b1, w, (idx == 3'd0), (idx == 3'd7), idx, port, ovf};
  endfunction

  task automatic set_port(input int p, input logic v, input logic [31:0] w, input logic l);
    req_valid_in[p]          = v;
    req_word_in[p*c_W +: c_W] = w;
    req_last_in[p]           = l;
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // One complete name from port p with n words, no stall. Starts in IDLE.
  task automatic run_name(input int p, input int n, input logic [31:0] base, input bit keep);
    set_port(p, 1'b1, base, (n == 1));
    cyc();
    chk($sformatf("bubble p%0d", p), obs_out(), 64'd0);
    chk($sformatf("busy p%0d", p), 64'(busy_out), 64'd1);
    chk($sformatf("rdy_grant p%0d", p), 64'(req_ready_out), 64'd1 << p);
    for (int i = 0; i < n; i++) begin
      cyc();
      if (i < 8)
        chk($sformatf("word p%0d i%0d", p, i), obs_out(),
            exp_vec(1'b1, base + 32'(i), 3'(i), 2'(p), (i == 7) && (n > 8)));
      else
        chk($sformatf("drain p%0d i%0d", p, i), obs_out(), 64'd0);
      if (i + 1 < n) begin
        set_port(p, 1'b1, base + 32'(i + 1), (i + 2 == n));
        chk($sformatf("rdy_mid p%0d i%0d", p, i), 64'(req_ready_out), 64'd1 << p);
      end else if (!keep) begin
        set_port(p, 1'b0, 32'd0, 1'b0);
      end
    end
    for (int j = n; j < 8; j++) begin
      chk($sformatf("rdy_pad p%0d j%0d", p, j), 64'(req_ready_out), 64'd0);
      cyc();
      chk($sformatf("pad p%0d j%0d", p, j), obs_out(), exp_vec(1'b1, 32'd0, 3'(j), 2'(p), 1'b0));
    end
    chk($sformatf("idle_busy p%0d", p), 64'(busy_out), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_in      = 1'b0;
    req_valid_in  = '0;
    req_word_in   = '0;
    req_last_in   = '0;
    pipe_stall_in = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_out", obs_out(), 64'd0);
    chk("rst_rdy", 64'(req_ready_out), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    cyc();
    chk("idle_no_req", 64'(busy_out), 64'd0);

    // All ports valid: grants 0,1,2,3,0 with a bubble between names
    set_port(1, 1'b1, 32'h3100_0000, 1'b0);
    set_port(2, 1'b1, 32'h3200_0000, 1'b0);
    set_port(3, 1'b1, 32'h3300_0000, 1'b0);
    run_name(0, 8, 32'h3000_0000, 1'b1);
    run_name(1, 8, 32'h3100_0000, 1'b1);
    run_name(2, 8, 32'h3200_0000, 1'b1);
    run_name(3, 8, 32'h3300_0000, 1'b1);
    set_port(1, 1'b0, 32'd0, 1'b0);
    set_port(2, 1'b0, 32'd0, 1'b0);
    set_port(3, 1'b0, 32'd0, 1'b0);
    run_name(0, 8, 32'h3040_0000, 1'b0);

    // Single port 0, exact-length name
    run_name(0, 8, 32'h1000_0000, 1'b0);

    // Port 2 short name 0xA,0xB,0xC then 5 zero pads
    run_name(2, 3, 32'h0000_000A, 1'b0);

    // Port 1 over-long name: truncate, overflow pulse, drain 2 words
    run_name(1, 10, 32'h4000_0000, 1'b0);

    // Pointer now at 2: with ports 0 and 2 waiting, port 2 wins
    set_port(0, 1'b1, 32'hDEAD_0000, 1'b0);
    run_name(2, 8, 32'h2200_0000, 1'b0);
    set_port(0, 1'b0, 32'd0, 1'b0);

    // Stall at idx 4 for 3 cycles, valid drop at idx 6 (port 0)
    set_port(0, 1'b1, 32'h5000_0000, 1'b0);
    cyc();
    chk("st_bubble", obs_out(), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("st_word i%0d", i), obs_out(),
          exp_vec(1'b1, 32'h5000_0000 + 32'(i), 3'(i), 2'd0, 1'b0));
      set_port(0, 1'b1, 32'h5000_0000 + 32'(i + 1), 1'b0);
    end
    pipe_stall_in = 1'b1;
    #1;
    chk("st_rdy_stall", 64'(req_ready_out), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("st_hole k%0d", k), obs_out(), 64'd0);
    end
    pipe_stall_in = 1'b0;
    #1;
    chk("st_rdy_resume", 64'(req_ready_out), 64'd1);
    cyc();
    chk("st_word i4", obs_out(), exp_vec(1'b1, 32'h5000_0004, 3'd4, 2'd0, 1'b0));
    set_port(0, 1'b1, 32'h5000_0005, 1'b0);
    cyc();
    chk("st_word i5", obs_out(), exp_vec(1'b1, 32'h5000_0005, 3'd5, 2'd0, 1'b0));
    set_port(0, 1'b0, 32'h5000_0006, 1'b0);
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk($sformatf("st_drop k%0d", k), obs_out(), 64'd0);
    end
    set_port(0, 1'b1, 32'h5000_0006, 1'b0);
    cyc();
    chk("st_word i6", obs_out(), exp_vec(1'b1, 32'h5000_0006, 3'd6, 2'd0, 1'b0));
    set_port(0, 1'b1, 32'h5000_0007, 1'b1);
    cyc();
    chk("st_word i7", obs_out(), exp_vec(1'b1, 32'h5000_0007, 3'd7, 2'd0, 1'b0));
    set_port(0, 1'b0, 32'd0, 1'b0);
    chk("st_idle", 64'(busy_out), 64'd0);

    // Asynchronous reset mid-name on port 2 (pointer at 1)
    set_port(2, 1'b1, 32'h6000_0000, 1'b0);
    cyc();
    chk("ar_bubble", obs_out(), 64'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("ar_word i%0d", i), obs_out(),
          exp_vec(1'b1, 32'h6000_0000 + 32'(i), 3'(i), 2'd2, 1'b0));
      set_port(2, 1'b1, 32'h6000_0000 + 32'(i + 1), 1'b0);
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("ar_out", obs_out(), 64'd0);
    chk("ar_rdy", 64'(req_ready_out), 64'd0);
    chk("ar_busy", 64'(busy_out), 64'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    // Ports 0 and 2 waiting; a cleared pointer picks port 0
    run_name(0, 8, 32'h7000_0000, 1'b0);
    set_port(2, 1'b0, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/name_inject_arbiter.md
# name_inject_arbiter

Round-robin scheduler that shares the FIB lookup pipeline input among `NUM_PORTS` ingress requesters. It accepts name components as word streams, one name at a time per requester. It serialises each name onto the single `name_component` input of the lookup `top`, always emitting exactly `MAX_NAME_LENGTH` words per name: short names are zero-padded and over-long names are truncated. The block sits directly in front of `top`, replacing hand-driven component sequencing.

## Interface
- `WORD_SIZE`, 32: name component width
- `MAX_NAME_LENGTH`, 8: words emitted per name
- `NUM_PORTS`, 4: number of requesters
- `clk_in`  in  1  clock; all state on rising edge
- `rst_n_in`  in  1  reset; asynchronous, active-low
- `req_valid_in`  in  NUM_PORTS  per-port word valid
- `req_word_in`  in  NUM_PORTS*WORD_SIZE  per-port word; port p occupies bits [p*WORD_SIZE +: WORD_SIZE]
- `req_last_in`  in  NUM_PORTS  per-port last word of name
- `req_ready_out`  out  NUM_PORTS  per-port accept; at most one bit high
- `pipe_stall_in`  in  1  downstream hold; no word is emitted while high
- `name_component_out`  out  WORD_SIZE  word to lookup pipeline
- `comp_valid_out`  out  1  `name_component_out` valid
- `comp_first_out`  out  1  word index 0 of a name
- `comp_last_out`  out  1  word index MAX_NAME_LENGTH-1
- `comp_idx_out`  out  IDX_W  word index within name
- `comp_port_out`  out  PORT_W  source port of current name
- `overflow_out`  out  1  one-cycle pulse: current name truncated
- `busy_out`  out  1  state != IDLE

## Operation
- `PORT_W = $clog2(NUM_PORTS)`, `IDX_W = $clog2(MAX_NAME_LENGTH)`; `word_idx` counts 0..MAX_NAME_LENGTH-1 and never wraps mid-name.
- FSM states: IDLE, STREAM, PAD, DRAIN.
- IDLE:
  - If any `req_valid_in` is set, grant the first valid port at or after `rr_ptr` (circular search) and latch it in `grant`.
  - Set `word_idx`=0 and go to STREAM. No word is accepted in this cycle, giving one bubble between names.
- STREAM:
  - `req_ready_out[grant] = !pipe_stall_in`.
  - Handshake occurs when valid && ready: emit the word and increment `word_idx`.
  - If `last` is set and `word_idx` == MAX-1, the name is complete; go to IDLE.
  - If `last` is set and `word_idx` < MAX-1, go to PAD.
  - If `last` is clear and `word_idx` == MAX-1, pulse `overflow_out` and go to DRAIN.
  - If the granted port drops valid, emit nothing (bubble) and stay in STREAM.
- PAD:
  - Emit zero words, one per non-stalled cycle, until index MAX-1 is emitted; then go to IDLE.
  - All `req_ready_out` are 0.
- DRAIN:
  - `req_ready_out[grant]`=1 regardless of stall; accepted words are discarded (no `comp_valid_out`).
  - Go to IDLE on an accepted word with `last` set.
- Name completion (entry to IDLE from STREAM, PAD or DRAIN): `rr_ptr` <= (grant+1) mod NUM_PORTS.
- Non-granted ports never see ready.

## Timing
- All outputs are registered. A word handshaken in cycle t appears on `name_component_out` with `comp_valid_out`=1 in cycle t+1, for one cycle.
- `comp_first_out`, `comp_last_out`, `comp_idx_out` and `comp_port_out` are aligned with `comp_valid_out`; they are 0 when it is low.
- Stall: while `pipe_stall_in`=1 in STREAM/PAD there is no handshake, no emission and the state is held; `comp_valid_out` is 0 the following cycle.
- Minimum name period: 1 + MAX_NAME_LENGTH cycles (9 at defaults).
- Reset (asynchronous, any time including mid-name):
  - state=IDLE, `rr_ptr`=0, `grant`=0, `word_idx`=0.
  - All outputs 0, including `req_ready_out`.
  - A partially emitted name is abandoned; the downstream consumer discards incomplete names via `comp_first_out`.
- `overflow_out` rises in the cycle after the MAX-th word handshake, together with that word's `comp_last_out`.

## Structure
- Package `ndn_fib_pkg`: `WORD_SIZE`, `MAX_NAME_LENGTH`, the FSM state enum `inj_state_t`, and the `word_t` typedef.
- Sub-module `rr_arbiter` (NUM_PORTS, PORT_W): combinational circular priority pick from `req` and `rr_ptr`, producing `gnt_idx` and `any`.
- Top-level FSM, counter and output registers stay in `name_inject_arbiter`.

## Test plan
- Single port 0, 8-word name, `last` on word 8, no stall -> 8 valid outputs, idx 0..7, first at idx0, last at idx7, port 0, no overflow.
- Port 2, 3-word name 0xA,0xB,0xC -> outputs 0xA,0xB,0xC followed by 5 zero words; `req_ready_out[2]` low from the 4th cycle; `comp_last_out` at idx7.
- All four ports continuously valid with 8-word names -> grant order 0,1,2,3,0; one idle bubble between names; no ready ever high on a non-granted port.
- Port 1, 10-word name -> 8 words emitted, `overflow_out` pulse with idx7; words 9–10 accepted and dropped; next grant to port 2.
- `pipe_stall_in` high for 3 cycles at idx 4 and granted port dropping valid at idx 6 -> no `comp_valid_out` during the holes; word order and indices intact.
- Assert `rst_n_in` low at idx 5, asynchronously between clock edges -> all outputs 0 immediately; after release, the next name is granted starting from port 0.
